net_switch_nxn: RTL and testbench
=================================

Name: net_switch_nxn

Overview:
- Parametrised NxN packet switch; successor to the fixed 2x2 random-select switch.
- Each input steers packets by destination field into a per-(input,output) virtual output queue (VOQ) of configurable depth.
- Each output drains its N VOQs through a fair round-robin arbiter into a registered valid/ready output stage.
- Sits between network_if-style producers and consumers in the switch testbench.

Parameters:
- N, 4, number of input and output ports (2..16).
- DW, 32, payload width in bits.
- DEPTH, 4, entries per VOQ (power of 2, >=2).
- IW, $clog2(N), derived (localparam): src/dst field width.
- W, DW+2*IW, derived (localparam): packet width, layout {src[IW-1:0], dst[IW-1:0], payload[DW-1:0]}.

Ports:
- clk  in  1  single clock, all state on posedge.
- rstn  in  1  asynchronous active-low reset.
- in_vld  in  N  per-input valid.
- in_rdy  out  N  per-input ready.
- in_data  in  N*W  per-input packet; port i at [i*W +: W].
- out_vld  out  N  per-output valid, registered.
- out_rdy  in  N  per-output ready.
- out_data  out  N*W  per-output packet, registered; port j at [j*W +: W].
- err_dst  out  N  one-cycle pulse per input: packet with dst>=N accepted and dropped.

Behaviour:
- Reset (rstn low, async): all VOQs empty; out_vld=0; out_data=0; err_dst=0; all RR pointers=0. in_rdy forced 0 while rstn low.
- Input routing: d = in_data[i] dst field.
  - If d<N: in_rdy[i] = !full(VOQ[i][d]), combinational on d and occupancy.
  - If d>=N (only possible when N not a power of 2): in_rdy[i]=1; on vld&&rdy the packet is discarded and err_dst[i] pulses high for the next cycle.
- Push on in_vld[i]&&in_rdy[i] at posedge; packet stored unmodified.
- Full means DEPTH entries. A full VOQ keeps in_rdy low even if it pops in the same cycle (no pass-through).
- Output stage j: out_reg loadable when !out_vld[j] || out_rdy[j].
  - When loadable and any VOQ[*][j] is non-empty, the arbiter grants the first non-empty i searching from ptr[j] upward, modulo N.
  - On grant: pop VOQ[i][j], load out_data[j], set out_vld[j]=1, and set ptr[j]=(i+1) mod N.
  - When loadable and all VOQ[*][j] are empty: out_vld[j]<=0; out_data holds its last value.
- Output hold: while out_vld[j]&&!out_rdy[j], out_data[j] and out_vld[j] remain stable; no pop, pointer unchanged.
- Latency: a packet pushed at edge E0 into an empty VOQ, with output j idle, shows out_vld at E1. Sustained throughput is 1 packet/cycle/output.
- Simultaneous push and pop on the same VOQ: both occur; occupancy unchanged.
- Pointers wrap N-1 -> 0. Counters are IW/clog2(DEPTH)+1 bits wide; no overflow is possible given the full check.
- Per-VOQ ordering is preserved (FIFO). No ordering guarantee exists across different inputs.
- Reset asserted mid-traffic: all in-flight packets are lost; outputs drop within the reset assertion, without waiting for clk.

Test Plan:
- N=4, DEPTH=4: input 0 sends 4 packets dst=2, payload 0..3, out_rdy=all 1 -> out 2 emits 0,1,2,3 in order, first one cycle after first accept, one per cycle; other outputs stay out_vld=0.
- All 4 inputs send 3 packets each to dst=1 simultaneously, out_rdy[1]=1 -> out 1 src sequence is 0,1,2,3,0,1,2,3,0,1,2,3.
- out_rdy[3]=0, input 1 sends 6 packets dst=3 -> 5 accepted (4 in VOQ, 1 in out reg); in_rdy[1]=0 on 6th until out_rdy[3] rises; out_data[3] stable during stall.
- N=3 (IW=2): input 2 sends dst=3 -> in_rdy=1, err_dst[2] pulses exactly one cycle, no output activity.
- Stall output 0 only with out_rdy[0]=0: input 0 alternates dst 0/1 -> in_rdy[0] drops only when dst=0 VOQ is full; dst=1 traffic still flows.
- Assert rstn low asynchronously between edges with packets queued -> out_vld/in_rdy go 0 immediately; after release, no stale packet appears.

Source files
------------

// File: rtl/net_switch_nxn.sv
// rtl/net_switch_nxn.sv - NxN packet switch with virtual output queues and round-robin outputs
// Each (input, output) pair owns a FIFO; each output drains its column of FIFOs round-robin.
module net_switch_nxn #(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  localparam int IW    = $clog2(N),
  localparam int W     = DW + 2 * IW
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   in_vld,
  output logic [N-1:0]   in_rdy,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   out_vld,
  input  logic [N-1:0]   out_rdy,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   err_dst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NQ = N * N;
  localparam logic [IW:0]   N_L  = (IW+1)'(N);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // VOQ[i][j] lives at flat index i*N + j
  logic [W-1:0]   mem_q [NQ][DEPTH];
  logic [W-1:0]   mem_d [NQ][DEPTH];
  logic [AW-1:0]  wp_q [NQ];
  logic [AW-1:0]  wp_d [NQ];
  logic [AW-1:0]  rp_q [NQ];
  logic [AW-1:0]  rp_d [NQ];
  logic [CW-1:0]  cnt_q [NQ];
  logic [CW-1:0]  cnt_d [NQ];
  logic [IW-1:0]  ptr_q [N];
  logic [IW-1:0]  ptr_d [N];
  logic [N-1:0]   out_vld_q, out_vld_d;
  logic [N*W-1:0] out_data_q, out_data_d;
  logic [N-1:0]   err_dst_q, err_dst_d;
  logic [NQ-1:0]  push, pop;
  logic [IW-1:0]  dst;
  logic           dst_bad;
  logic           found;
  int             v;
  int             g;

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign err_dst  = err_dst_q;

  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    err_dst_d  = '0;
    push       = '0;
    pop        = '0;
    in_rdy     = '0;
    dst        = '0;
    dst_bad    = 1'b0;
    found      = 1'b0;
    v          = 0;
    g          = 0;

    for (int i = 0; i < N; i++) begin
      dst     = in_data[i*W + DW +: IW];
      dst_bad = ({1'b0, dst} >= N_L);
      v       = dst_bad ? 0 : i * N + int'(dst);
      // Out-of-range destinations are always accepted so the producer never stalls on them
      in_rdy[i] = rstn && (dst_bad || (cnt_q[v] != FULL));
      if (in_vld[i] && in_rdy[i]) begin
        if (dst_bad) begin
          err_dst_d[i] = 1'b1;
        end else begin
          push[v]              = 1'b1;
          mem_d[v][wp_q[v]]    = in_data[i*W +: W];
          wp_d[v]              = wp_q[v] + 1'b1;
        end
      end
    end

    for (int j = 0; j < N; j++) begin
      if (!out_vld_q[j] || out_rdy[j]) begin
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
          v = (int'(ptr_q[j]) + k) % N;
          if (!found && (cnt_q[v*N + j] != '0)) begin
            found = 1'b1;
            g     = v;
          end
        end
        if (found) begin
          v                      = g * N + j;
          pop[v]                 = 1'b1;
          rp_d[v]                = rp_q[v] + 1'b1;
          out_data_d[j*W +: W]   = mem_q[v][rp_q[v]];
          out_vld_d[j]           = 1'b1;
          ptr_d[j]               = IW'((g + 1) % N);
        end else begin
          out_vld_d[j] = 1'b0;
        end
      end
    end

    // Occupancy only looks at pre-edge state, so a full queue never passes through
    for (int q = 0; q < NQ; q++) begin
      cnt_d[q] = cnt_q[q] + CW'(push[q]) - CW'(pop[q]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q       <= '{default: '0};
      rp_q       <= '{default: '0};
      cnt_q      <= '{default: '0};
      ptr_q      <= '{default: '0};
      out_vld_q  <= '0;
      out_data_q <= '0;
      err_dst_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      err_dst_q  <= err_dst_d;
    end
  end

  // Storage needs no reset: emptiness is carried by the counters
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_net_switch_nxn.sv
// tb/tb_net_switch_nxn.sv - self-checking bench for net_switch_nxn
// A queue-based reference model checks every cycle; directed sequences cover the corner cases.
module tb_net_switch_nxn;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int W     = DW + 2 * IW;
  localparam int N3    = 3;
  localparam int DW3   = 8;
  localparam int W3    = DW3 + 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0]    in_vld, in_rdy, out_vld, out_rdy, err_dst;
  logic [N*W-1:0]  in_data, out_data;
  logic [N3-1:0]   in_vld3, in_rdy3, out_vld3, out_rdy3, err_dst3;
  logic [N3*W3-1:0] in_data3, out_data3;

  logic [IW-1:0] dst_a [N];
  logic [DW-1:0] pay_a [N];

  logic [W-1:0]  mq [N][N][$];
  logic          m_vld [N];
  logic [W-1:0]  m_data [N];
  int            m_ptr [N];
  logic [N-1:0]  m_err;
  logic [N-1:0]  rdy_seen;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  net_switch_nxn #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .err_dst(err_dst)
  );

  net_switch_nxn #(.N(N3), .DW(DW3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rstn(rstn),
    .in_vld(in_vld3), .in_rdy(in_rdy3), .in_data(in_data3),
    .out_vld(out_vld3), .out_rdy(out_rdy3), .out_data(out_data3),
    .err_dst(err_dst3)
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] pay;
    logic          exp_rdy;
    logic [N-1:0]  exp_ovld;
    logic [W-1:0]  exp_d2;
  } vec_t;

  function automatic logic [W-1:0] mkpkt(int s, int d, logic [DW-1:0] p);
    return {IW'(s), IW'(d), p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = mkpkt(i, int'(dst_a[i]), pay_a[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) mq[i][j].delete();
      m_vld[i]  = 1'b0;
      m_data[i] = '0;
      m_ptr[i]  = 0;
    end
    m_err = '0;
  endtask

  // One clock edge of the switch: outputs draw on pre-edge contents, then accepted packets enqueue
  task automatic model_edge(input logic [N-1:0] mrdy);
    int  gi;
    bit  hit;
    for (int j = 0; j < N; j++) begin
      if (!m_vld[j] || out_rdy[j]) begin
        hit = 0;
        for (int k = 0; k < N && !hit; k++) begin
          gi = (m_ptr[j] + k) % N;
          if (mq[gi][j].size() > 0) begin
            hit       = 1;
            m_data[j] = mq[gi][j].pop_front();
            m_ptr[j]  = (gi + 1) % N;
          end
        end
        m_vld[j] = hit;
      end
    end
    m_err = '0;
    for (int i = 0; i < N; i++)
      if (in_vld[i] && mrdy[i]) mq[i][dst_a[i]].push_back(mkpkt(i, int'(dst_a[i]), pay_a[i]));
  endtask

  task automatic cycle();
    logic [N-1:0] mrdy;
    pack();
    #1;
    for (int i = 0; i < N; i++) begin
      mrdy[i] = (mq[i][dst_a[i]].size() < DEPTH);
      chk($sformatf("in_rdy[%0d]", i), 64'(in_rdy[i]), 64'(mrdy[i]));
    end
    rdy_seen = in_rdy;
    @(posedge clk);
    model_edge(mrdy);
    #1;
    for (int j = 0; j < N; j++) begin
      chk($sformatf("out_vld[%0d]", j), 64'(out_vld[j]), 64'(m_vld[j]));
      if (m_vld[j]) chk($sformatf("out_data[%0d]", j), 64'(out_data[j*W +: W]), 64'(m_data[j]));
    end
    chk("err_dst", 64'(err_dst), 64'(m_err));
  endtask

  task automatic do_reset();
    in_vld   = '0;
    out_rdy  = '1;
    in_vld3  = '0;
    in_data3 = '0;
    out_rdy3 = '1;
    for (int i = 0; i < N; i++) begin
      dst_a[i] = '0;
      pay_a[i] = '0;
    end
    pack();
    rstn = 1'b0;
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_out_data", 64'(out_data[W-1:0]), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(0));
    chk("rst_err_dst", 64'(err_dst), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tv[6];
    int   acc;
    int   nout;
    logic [IW-1:0] srcs[$];

    tv[0] = '{1'b1, 32'd0, 1'b1, 4'b0000, '0};
    tv[1] = '{1'b1, 32'd1, 1'b1, 4'b0100, mkpkt(0, 2, 32'd0)};
    tv[2] = '{1'b1, 32'd2, 1'b1, 4'b0100, mkpkt(0, 2, 32'd1)};
    tv[3] = '{1'b1, 32'd3, 1'b1, 4'b0100, mkpkt(0, 2, 32'd2)};
    tv[4] = '{1'b0, 32'd0, 1'b0, 4'b0100, mkpkt(0, 2, 32'd3)};
    tv[5] = '{1'b0, 32'd0, 1'b0, 4'b0000, '0};

    model_clear();
    do_reset();

    // Single input streaming into one output
    for (int t = 0; t < 6; t++) begin
      in_vld   = {3'b000, tv[t].vld};
      dst_a[0] = 2'd2;
      pay_a[0] = tv[t].pay;
      cycle();
      if (tv[t].vld) chk($sformatf("t1_rdy[%0d]", t), 64'(rdy_seen[0]), 64'(tv[t].exp_rdy));
      chk($sformatf("t1_ovld[%0d]", t), 64'(out_vld), 64'(tv[t].exp_ovld));
      if (tv[t].exp_ovld[2]) chk($sformatf("t1_data[%0d]", t), 64'(out_data[2*W +: W]), 64'(tv[t].exp_d2));
    end

    // Four inputs converge on output 1: round-robin by source
    do_reset();
    for (int c = 0; c < 16; c++) begin
      in_vld = (c < 3) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < N; i++) begin
        dst_a[i] = 2'd1;
        pay_a[i] = DW'(c);
      end
      cycle();
      if (out_vld[1]) srcs.push_back(out_data[2*W-1 -: IW]);
    end
    chk("t2_count", 64'(srcs.size()), 64'(12));
    for (int k = 0; k < srcs.size() && k < 12; k++)
      chk($sformatf("t2_src[%0d]", k), 64'(srcs[k]), 64'(k % 4));

    // Stalled output: VOQ plus output register absorb five packets
    do_reset();
    out_rdy  = 4'b0111;
    in_vld   = 4'b0010;
    dst_a[1] = 2'd3;
    acc      = 0;
    for (int c = 0; c < 10; c++) begin
      pay_a[1] = DW'(acc);
      cycle();
      if (rdy_seen[1]) acc++;
    end
    chk("t3_accepted", 64'(acc), 64'(5));
    chk("t3_rdy_low", 64'(rdy_seen[1]), 64'(0));
    chk("t3_hold_vld", 64'(out_vld[3]), 64'(1));
    chk("t3_hold_data", 64'(out_data[3*W +: DW]), 64'(0));
    out_rdy = 4'b1111;
    for (int c = 0; c < 8 && acc < 6; c++) begin
      pay_a[1] = DW'(acc);
      cycle();
      if (rdy_seen[1]) acc++;
    end
    chk("t3_sixth", 64'(acc), 64'(6));
    in_vld = '0;
    repeat (8) cycle();

    // Out-of-range destination on the 3-port switch
    do_reset();
    in_vld3 = 3'b100;
    in_data3[2*W3 +: W3] = {2'd2, 2'd3, 8'hA5};
    #1;
    chk("t4_rdy", 64'(in_rdy3[2]), 64'(1));
    cycle();
    chk("t4_err_pulse", 64'(err_dst3), 64'(3'b100));
    chk("t4_no_out", 64'(out_vld3), 64'(0));
    in_vld3 = '0;
    cycle();
    chk("t4_err_clear", 64'(err_dst3), 64'(0));
    chk("t4_no_out2", 64'(out_vld3), 64'(0));

    // Head-of-line isolation: stalled output 0 must not block output 1
    do_reset();
    out_rdy = 4'b1110;
    in_vld  = 4'b0001;
    nout    = 0;
    for (int k = 0; k < 12; k++) begin
      dst_a[0] = IW'(k % 2);
      pay_a[0] = DW'(k);
      cycle();
      if (k % 2 == 1) chk($sformatf("t5_rdy1[%0d]", k), 64'(rdy_seen[0]), 64'(1));
      else            chk($sformatf("t5_rdy0[%0d]", k), 64'(rdy_seen[0]), 64'(k < 10));
      if (out_vld[1]) nout++;
    end
    in_vld = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (out_vld[1]) nout++;
    end
    chk("t5_out1_count", 64'(nout), 64'(6));

    // Asynchronous reset with traffic queued
    do_reset();
    out_rdy  = 4'b0000;
    in_vld   = 4'b0100;
    dst_a[2] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      pay_a[2] = DW'(32'hC0 + k);
      cycle();
    end
    chk("t6_pre_vld", 64'(out_vld[0]), 64'(1));
    dst_a[2] = 2'd1;
    pack();
    #1;
    chk("t6_pre_rdy", 64'(in_rdy[2]), 64'(1));
    #1;
    rstn = 1'b0;
    #1;
    chk("t6_async_vld", 64'(out_vld), 64'(0));
    chk("t6_async_rdy", 64'(in_rdy), 64'(0));
    chk("t6_async_data", 64'(out_data[W-1:0]), 64'(0));
    in_vld = '0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    out_rdy = 4'b1111;
    nout    = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (out_vld != 0) nout++;
    end
    chk("t6_no_stale", 64'(nout), 64'(0));

    // Randomised traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_vld = N'($urandom);
      for (int i = 0; i < N; i++) begin
        dst_a[i]   = IW'($urandom);
        pay_a[i]   = $urandom;
        out_rdy[i] = ($urandom_range(3) != 0);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
